fetch_exec_sequencer: RTL and testbench
=======================================

Name: fetch_exec_sequencer

Overview:
- Control sequencer that drives the 6-bit program_counter and the other bus agents (MAR, RAM, IR, A, B, ALU, OUT) of the shared tri-state bus.
- Steps through a fixed six-T-state machine cycle: three fetch states, then three execute states decoded from the IR opcode.
- Each bus agent receives one or more load/enable strobes from this block.
- Supports free-run and single-step operation, and a halt state entered by the HLT opcode.

Parameters:
- OP_W, 4, width of opcode field taken from IR.
- OP_LDA, 4'h0, load A from memory[addr].
- OP_ADD, 4'h1, A <= A + memory[addr].
- OP_SUB, 4'h2, A <= A - memory[addr].
- OP_OUT, 4'hE, OUT <= A.
- OP_HLT, 4'hF, stop sequencing.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- clr  in  1  reset, asynchronous, active-high; also the only exit from HALT.
- start  in  1  level; leaves IDLE when high.
- step_mode  in  1  1 = single-step: hold in T1 until step is high.
- step  in  1  advance permission in step_mode; sampled only in T1.
- opcode  in  OP_W  IR opcode field; sampled at end of T3.
- pc_en  out  1  PC drives bus.
- pc_incr  out  1  PC increments.
- mar_load  out  1  MAR loads bus.
- ram_en  out  1  RAM drives bus.
- ir_load  out  1  IR loads bus.
- ir_en  out  1  IR address field drives bus.
- a_load  out  1  A loads bus.
- a_en  out  1  A drives bus.
- b_load  out  1  B loads bus.
- alu_en  out  1  ALU result drives bus.
- alu_sub  out  1  ALU subtracts.
- out_load  out  1  OUT register loads bus.
- tstate  out  3  current state code.
- halted  out  1  high in HALT.

Behaviour:
- States and 3-bit encodings:
  - IDLE = 0
  - T1..T6 = 1..6
  - HALT = 7
- clr asserted at any time, including mid-instruction:
  - state -> IDLE and op_q -> 0 immediately.
  - All control outputs are 0; halted = 0; tstate = 0.
- Transitions:
  - IDLE -> T1 when start = 1, else stay in IDLE.
  - T1 -> T2 if step_mode = 0, or if (step_mode = 1 and step = 1); otherwise stay in T1. While T1 is held, its outputs stay asserted (idempotent).
  - T2 -> T3 -> T4 unconditionally.
  - T4 -> HALT if op_q = OP_HLT, else T4 -> T5.
  - T5 -> T6 -> T1.
  - HALT is absorbing; only clr leaves it. start and step are ignored in HALT.
- op_q: internal register capturing opcode on the rising edge that leaves T3. Execute decode uses op_q only; opcode changes at any other time have no effect.
- Outputs are Moore: combinational decode of state and op_q, with no registered latency. An asserted control is valid for the whole state cycle.
- Fetch:
  - T1: pc_en, mar_load.
  - T2: pc_incr.
  - T3: ram_en, ir_load.
- Execute:
  - LDA: T4 ir_en + mar_load; T5 ram_en + a_load; T6 none.
  - ADD: T4 ir_en + mar_load; T5 ram_en + b_load; T6 alu_en + a_load.
  - SUB: as ADD, with alu_sub also high in T6.
  - OUT: T4 a_en + out_load; T5, T6 none.
  - HLT: T4 none; HALT next.
  - Undefined opcodes: NOP, i.e. T4–T6 all controls 0, then T1.
- Invariant: at most one of {pc_en, ram_en, ir_en, a_en, alu_en} is high in any cycle (bus contention guard); the bench asserts this every cycle.
- PC wrap-around (63 -> 0) is owned by program_counter. The sequencer issues exactly one pc_incr per instruction, in T2, regardless of opcode.
- Instruction length is 6 cycles for every opcode except HLT, which uses T1–T4 and then HALT.

Decomposition:
- Shared package: state encodings (IDLE, T1–T6, HALT) and opcode constants OP_*, reused by the IR/assembler testbenches.
- One natural sub-module, control_decode: purely combinational map from (state, op_q) to the control word.
- The top holds the state register, op_q, and the step/start gating.

Test Plan:
- Reset/idle: clr = 1 mid-T5 of an ADD -> next sample state = 0 with all controls 0. With start = 0 for 10 cycles -> tstate stays 0.
- LDA fetch/exec: start = 1, opcode = 4'h0 -> cycle-by-cycle controls as below, then tstate returns to 1.
  - T1: pc_en + mar_load.
  - T2: pc_incr.
  - T3: ram_en + ir_load.
  - T4: ir_en + mar_load.
  - T5: ram_en + a_load.
  - T6: none.
- SUB vs ADD: opcode = 4'h2 -> T6 has alu_en = a_load = alu_sub = 1. opcode = 4'h1 -> same T6 but alu_sub = 0. Changing opcode during T4–T6 does not alter outputs.
- HLT: opcode = 4'hF -> T4 all controls 0, next cycle halted = 1 and tstate = 7. Toggling start/step for 20 cycles keeps the block in HALT. clr -> IDLE.
- Single-step: step_mode = 1, step = 0 for 5 cycles -> held in T1 with pc_en = 1, pc_incr never pulses. step = 1 for one cycle -> T2 with exactly one pc_incr pulse.
- Wrap and contention: 64 consecutive NOP instructions (opcode = 4'h5) -> exactly 64 pc_incr pulses, so the PC wraps to 0. No cycle has more than one bus-drive enable.

Source files
------------

// File: rtl/fetch_exec_sequencer_pkg.sv
// Shared definitions for the fetch/execute sequencer: T-state encodings,
// opcode constants and the packed control word handed to the bus agents.
package fetch_exec_sequencer_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_LDA = 4'h0;
  localparam logic [OP_W-1:0] OP_ADD = 4'h1;
  localparam logic [OP_W-1:0] OP_SUB = 4'h2;
  localparam logic [OP_W-1:0] OP_OUT = 4'hE;
  localparam logic [OP_W-1:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_T1   = 3'd1,
    ST_T2   = 3'd2,
    ST_T3   = 3'd3,
    ST_T4   = 3'd4,
    ST_T5   = 3'd5,
    ST_T6   = 3'd6,
    ST_HALT = 3'd7
  } state_t;

  typedef struct packed {
    logic pc_en;
    logic pc_incr;
    logic mar_load;
    logic ram_en;
    logic ir_load;
    logic ir_en;
    logic a_load;
    logic a_en;
    logic b_load;
    logic alu_en;
    logic alu_sub;
    logic out_load;
  } ctrl_t;

endpackage

// File: rtl/fetch_exec_sequencer_control_decode.sv
// Purely combinational map from (T-state, latched opcode) to the control word.
// IDLE and HALT decode to an all-zero word.
module control_decode
  import fetch_exec_sequencer_pkg::*;
(
  input  state_t          state,
  input  logic [OP_W-1:0] op_q,
  output ctrl_t           ctrl
);

  // Moore decode: fetch states are opcode-independent, execute states use op_q
  always_comb begin
    ctrl = '0;
    case (state)
      ST_T1: begin
        ctrl.pc_en    = 1'b1;
        ctrl.mar_load = 1'b1;
      end
      ST_T2: ctrl.pc_incr = 1'b1;
      ST_T3: begin
        ctrl.ram_en  = 1'b1;
        ctrl.ir_load = 1'b1;
      end
      ST_T4: begin
        case (op_q)
          OP_LDA, OP_ADD, OP_SUB: begin
            ctrl.ir_en    = 1'b1;
            ctrl.mar_load = 1'b1;
          end
          OP_OUT: begin
            ctrl.a_en     = 1'b1;
            ctrl.out_load = 1'b1;
          end
          default: ;
        endcase
      end
      ST_T5: begin
        case (op_q)
          OP_LDA: begin
            ctrl.ram_en = 1'b1;
            ctrl.a_load = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            ctrl.ram_en = 1'b1;
            ctrl.b_load = 1'b1;
          end
          default: ;
        endcase
      end
      ST_T6: begin
        case (op_q)
          OP_ADD: begin
            ctrl.alu_en = 1'b1;
            ctrl.a_load = 1'b1;
          end
          OP_SUB: begin
            ctrl.alu_en  = 1'b1;
            ctrl.a_load  = 1'b1;
            ctrl.alu_sub = 1'b1;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/fetch_exec_sequencer.sv
// Six-T-state fetch/execute sequencer: holds the state register and the
// latched opcode, gates start/step, and fans the decoded control word out.
module fetch_exec_sequencer
  import fetch_exec_sequencer_pkg::*;
(
  input  logic            clk,
  input  logic            clr,
  input  logic            start,
  input  logic            step_mode,
  input  logic            step,
  input  logic [OP_W-1:0] opcode,
  output logic            pc_en,
  output logic            pc_incr,
  output logic            mar_load,
  output logic            ram_en,
  output logic            ir_load,
  output logic            ir_en,
  output logic            a_load,
  output logic            a_en,
  output logic            b_load,
  output logic            alu_en,
  output logic            alu_sub,
  output logic            out_load,
  output logic [2:0]      tstate,
  output logic            halted
);

  state_t          r_state;
  state_t          w_next;
  logic [OP_W-1:0] r_op_q;
  ctrl_t           w_ctrl;

  // State register; clr is the only way out of HALT
  always_ff @(posedge clk or posedge clr) begin
    if (clr) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Opcode is captured only on the edge leaving T3
  always_ff @(posedge clk or posedge clr) begin
    if (clr)                  r_op_q <= '0;
    else if (r_state == ST_T3) r_op_q <= opcode;
  end

  // Next-state logic with start and single-step gating
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (start) w_next = ST_T1;
      ST_T1:   if (!step_mode || step) w_next = ST_T2;
      ST_T2:   w_next = ST_T3;
      ST_T3:   w_next = ST_T4;
      ST_T4:   w_next = (r_op_q == OP_HLT) ? ST_HALT : ST_T5;
      ST_T5:   w_next = ST_T6;
      ST_T6:   w_next = ST_T1;
      ST_HALT: w_next = ST_HALT;
      default: w_next = ST_IDLE;
    endcase
  end

  control_decode u_decode (
    .state (r_state),
    .op_q  (r_op_q),
    .ctrl  (w_ctrl)
  );

  assign pc_en    = w_ctrl.pc_en;
  assign pc_incr  = w_ctrl.pc_incr;
  assign mar_load = w_ctrl.mar_load;
  assign ram_en   = w_ctrl.ram_en;
  assign ir_load  = w_ctrl.ir_load;
  assign ir_en    = w_ctrl.ir_en;
  assign a_load   = w_ctrl.a_load;
  assign a_en     = w_ctrl.a_en;
  assign b_load   = w_ctrl.b_load;
  assign alu_en   = w_ctrl.alu_en;
  assign alu_sub  = w_ctrl.alu_sub;
  assign out_load = w_ctrl.out_load;
  assign tstate   = r_state;
  assign halted   = (r_state == ST_HALT);

endmodule

// File: tb/tb_fetch_exec_sequencer.sv
// Self-checking bench for fetch_exec_sequencer: table-driven instruction
// vectors plus hand-written reset, halt, single-step and wrap sequences.
module tb_fetch_exec_sequencer;

  logic       clk = 1'b0;
  logic       clr, start, step_mode, step;
  logic [3:0] opcode;
  logic       pc_en, pc_incr, mar_load, ram_en, ir_load, ir_en;
  logic       a_load, a_en, b_load, alu_en, alu_sub, out_load;
  logic [2:0] tstate;
  logic       halted;

  int checks = 0;
  int errors = 0;

  // Control word bit masks, order {pc_en .. out_load}
  localparam logic [11:0] M_PC_EN    = 12'h800;
  localparam logic [11:0] M_PC_INCR  = 12'h400;
  localparam logic [11:0] M_MAR_LOAD = 12'h200;
  localparam logic [11:0] M_RAM_EN   = 12'h100;
  localparam logic [11:0] M_IR_LOAD  = 12'h080;
  localparam logic [11:0] M_IR_EN    = 12'h040;
  localparam logic [11:0] M_A_LOAD   = 12'h020;
  localparam logic [11:0] M_A_EN     = 12'h010;
  localparam logic [11:0] M_B_LOAD   = 12'h008;
  localparam logic [11:0] M_ALU_EN   = 12'h004;
  localparam logic [11:0] M_ALU_SUB  = 12'h002;
  localparam logic [11:0] M_OUT_LOAD = 12'h001;

  localparam logic [11:0] F_T1 = M_PC_EN | M_MAR_LOAD;
  localparam logic [11:0] F_T2 = M_PC_INCR;
  localparam logic [11:0] F_T3 = M_RAM_EN | M_IR_LOAD;

  typedef struct {
    string       name;
    logic [3:0]  op;       // opcode driven during T1..T3
    logic [3:0]  late_op;  // opcode driven during T4..T6 (must be ignored)
    logic [11:0] exp [6];  // expected control word in T1..T6
  } vec_t;

  vec_t vecs [6];

  fetch_exec_sequencer dut (
    .clk       (clk),
    .clr       (clr),
    .start     (start),
    .step_mode (step_mode),
    .step      (step),
    .opcode    (opcode),
    .pc_en     (pc_en),
    .pc_incr   (pc_incr),
    .mar_load  (mar_load),
    .ram_en    (ram_en),
    .ir_load   (ir_load),
    .ir_en     (ir_en),
    .a_load    (a_load),
    .a_en      (a_en),
    .b_load    (b_load),
    .alu_en    (alu_en),
    .alu_sub   (alu_sub),
    .out_load  (out_load),
    .tstate    (tstate),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] ctrl_word();
    return {pc_en, pc_incr, mar_load, ram_en, ir_load, ir_en,
            a_load, a_en, b_load, alu_en, alu_sub, out_load};
  endfunction

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int idx, input string name, input logic [3:0] op,
                         input logic [3:0] late, input logic [11:0] e4,
                         input logic [11:0] e5, input logic [11:0] e6);
    vecs[idx].name    = name;
    vecs[idx].op      = op;
    vecs[idx].late_op = late;
    vecs[idx].exp[0]  = F_T1;
    vecs[idx].exp[1]  = F_T2;
    vecs[idx].exp[2]  = F_T3;
    vecs[idx].exp[3]  = e4;
    vecs[idx].exp[4]  = e5;
    vecs[idx].exp[5]  = e6;
  endtask

  // Bus contention guard, sampled mid-cycle
  always @(negedge clk) begin
    checks++;
    if ((int'(pc_en) + int'(ram_en) + int'(ir_en) + int'(a_en) + int'(alu_en)) > 1) begin
      errors++;
      $display("FAIL bus_contention: t=%0t drivers pc=%0b ram=%0b ir=%0b a=%0b alu=%0b expected at most one",
               $time, pc_en, ram_en, ir_en, a_en, alu_en);
    end
  end

  initial begin
    int pulses;
    logic [5:0] pc_model;

    set_vec(0, "LDA", 4'h0, 4'h0, M_IR_EN | M_MAR_LOAD, M_RAM_EN | M_B_LOAD & 12'h0 | M_RAM_EN | M_A_LOAD, 12'h000);
    set_vec(1, "ADD", 4'h1, 4'h2, M_IR_EN | M_MAR_LOAD, M_RAM_EN | M_B_LOAD, M_ALU_EN | M_A_LOAD);
    set_vec(2, "SUB", 4'h2, 4'h1, M_IR_EN | M_MAR_LOAD, M_RAM_EN | M_B_LOAD, M_ALU_EN | M_A_LOAD | M_ALU_SUB);
    set_vec(3, "OUT", 4'hE, 4'hF, M_A_EN | M_OUT_LOAD, 12'h000, 12'h000);
    set_vec(4, "NOP5", 4'h5, 4'h0, 12'h000, 12'h000, 12'h000);
    set_vec(5, "NOPA", 4'hA, 4'h1, 12'h000, 12'h000, 12'h000);

    clr = 1'b1; start = 1'b0; step_mode = 1'b0; step = 1'b0; opcode = 4'h0;
    tick(); tick();
    check("reset_tstate", tstate, 0);
    check("reset_ctrl", ctrl_word(), 0);
    check("reset_halted", halted, 0);
    clr = 1'b0;

    // Idle with start low
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_tstate", tstate, 0);
    end

    start = 1'b1;
    tick();
    check("start_t1", tstate, 1);

    // Table-driven instruction vectors, free-running
    for (int v = 0; v < 6; v++) begin
      for (int k = 0; k < 6; k++) begin
        opcode = (k >= 3) ? vecs[v].late_op : vecs[v].op;
        #1;
        check({vecs[v].name, "_tstate"}, tstate, k + 1);
        check({vecs[v].name, "_ctrl_T", $sformatf("%0d", k + 1)}, ctrl_word(), vecs[v].exp[k]);
        tick();
      end
      check({vecs[v].name, "_return_t1"}, tstate, 1);
    end

    // clr in the middle of T5 of an ADD
    opcode = 4'h1;
    tick(); tick(); tick(); tick();
    check("add_t5", tstate, 5);
    check("add_t5_ctrl", ctrl_word(), M_RAM_EN | M_B_LOAD);
    clr = 1'b1;
    #1;
    check("midclr_tstate", tstate, 0);
    check("midclr_ctrl", ctrl_word(), 0);
    tick();
    clr = 1'b0;
    tick();
    check("after_clr_t1", tstate, 1);

    // HLT: T1..T4 then absorbing HALT
    opcode = 4'hF;
    tick(); tick(); tick();
    check("hlt_t4", tstate, 4);
    check("hlt_t4_ctrl", ctrl_word(), 0);
    tick();
    check("hlt_tstate", tstate, 7);
    check("hlt_halted", halted, 1);
    check("hlt_ctrl", ctrl_word(), 0);
    for (int i = 0; i < 20; i++) begin
      start = i[0];
      step = ~i[0];
      step_mode = i[1];
      tick();
      check("halt_hold", tstate, 7);
    end
    clr = 1'b1; start = 1'b0; step = 1'b0; step_mode = 1'b0;
    #1;
    check("halt_clr_tstate", tstate, 0);
    check("halt_clr_halted", halted, 0);
    tick();
    clr = 1'b0;
    tick();
    check("halt_clr_idle", tstate, 0);

    // Single-step: held in T1 until step
    step_mode = 1'b1; step = 1'b0; start = 1'b1; opcode = 4'h5;
    tick();
    check("ss_t1", tstate, 1);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (pc_incr) pulses++;
      check("ss_hold_tstate", tstate, 1);
      check("ss_hold_pc_en", pc_en, 1);
    end
    check("ss_no_incr", pulses, 0);
    step = 1'b1;
    tick();
    step = 1'b0;
    check("ss_t2", tstate, 2);
    check("ss_incr", pc_incr, 1);
    tick();
    check("ss_t3", tstate, 3);
    check("ss_incr_once", pc_incr, 0);
    tick(); tick(); tick(); tick();
    check("ss_back_t1", tstate, 1);
    step_mode = 1'b0;

    // 64 NOP instructions: PC model wraps to 0
    pulses = 0;
    pc_model = 6'd0;
    for (int c = 0; c < 64 * 6; c++) begin
      if (pc_incr) begin
        pulses++;
        pc_model = pc_model + 6'd1;
      end
      tick();
    end
    check("wrap_pulses", pulses, 64);
    check("wrap_pc", pc_model, 0);
    check("wrap_t1", tstate, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
